// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file sizing for the Part1 RISC-V datapath
// Contents: default DATA_W/NREGS, REG_ZERO index, and the register-address
// width function used by decode, the ALU operand mux and the register file.
package riscv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 8;
  localparam int REG_ZERO   = 0;

  // Register-index width; NREGS is a power of two >= 2, so this is never 0.
  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register-file access bus (one write port, two read ports)
// Signals: we, wr_addr, wr_data  - write port (driven by the write-back stage)
//          rd_addr_a, rd_addr_b  - read indices (driven by decode)
//          rd_data_a, rd_data_b  - read data (driven by the register file)
//          wr_count              - committed non-zero-register write count (debug)
// Modports: master = datapath side, slave = register file side.
interface reg_file_if
  import riscv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
);

  localparam int AW = addr_w(NREGS);

  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [7:0]        wr_count;

  modport master (
    output we, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_count
  );

endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file, x0 hard-wired to zero
// Ports: clk - rising-edge clock
//        rst - asynchronous active-high reset (clears registers and wr_count)
//        bus - reg_file_if.slave: one synchronous write port, two
//              combinational read ports, wr_count debug counter
// BYPASS=1 forwards the in-flight write data to a matching read port.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int AW = addr_w(NREGS);

  typedef logic [DATA_W-1:0] word_t;

  // Register 0 has no storage; the array starts at index 1.
  word_t      regs_q [1:NREGS-1];
  logic [7:0] wr_count_q;
  logic [7:0] wr_count_d;
  logic       wr_hit;

  // Writes to x0 are accepted on the bus but never commit.
  assign wr_hit     = bus.we && (bus.wr_addr != AW'(REG_ZERO));
  assign wr_count_d = wr_count_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wr_hit) begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.wr_addr == AW'(i)) begin
          regs_q[i] <= bus.wr_data;
        end
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Shared read-port selection. Index 0 falls through the loop and the
  // bypass compare (wr_hit excludes x0), so it always returns zero. The
  // bypass path stays live during reset because it is purely combinational.
  function automatic word_t read_port(
    input word_t         regs [1:NREGS-1],
    input logic [AW-1:0] ra,
    input logic          hit,
    input logic [AW-1:0] wa,
    input word_t         wd
  );
    word_t v;
    v = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ra == AW'(i)) begin
        v = regs[i];
      end
    end
    if ((BYPASS != 0) && hit && (ra == wa)) begin
      v = wd;
    end
    return v;
  endfunction

  always_comb begin
    bus.rd_data_a = read_port(regs_q, bus.rd_addr_a, wr_hit, bus.wr_addr, bus.wr_data);
  end

  always_comb begin
    bus.rd_data_b = read_port(regs_q, bus.rd_addr_b, wr_hit, bus.wr_addr, bus.wr_data);
  end

  assign bus.wr_count = wr_count_q;

endmodule
